// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: req/ready accept, WAIT_CYCLES busy, one-cycle ack.
// Optional write tracing is compiled in with DM_TRACE_EN.
module dm_responder #(
  parameter int DEPTH       = 3072,
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        ready,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] pc_q;
  logic [31:0] mem [DEPTH];

  logic              accept;
  logic              commit;
  logic              c_we;
  logic [3:0]        c_be;
  logic [31:0]       c_addr;
  logic [31:0]       c_wdata;
  logic [31:0]       c_pc;
  logic [ADDR_W-1:0] c_idx;
  logic              in_range;
  logic [31:0]       cur;
  logic [31:0]       merged;
  logic              unused_bits;

  assign accept = req & ready & (state == IDLE);

  // With zero wait states the commit happens on the accept edge itself
  assign commit = (accept && WAIT_CYCLES == 0) ||
                  (state == BUSY && cnt == 4'd0);

  assign c_we    = (state == IDLE) ? we    : we_q;
  assign c_be    = (state == IDLE) ? be    : be_q;
  assign c_addr  = (state == IDLE) ? addr  : addr_q;
  assign c_wdata = (state == IDLE) ? wdata : wdata_q;
  assign c_pc    = (state == IDLE) ? pc    : pc_q;

  assign c_idx    = c_addr[ADDR_W+1:2];
  assign in_range = {1'b0, c_idx} < DEPTH_L;

  assign unused_bits = ^{c_addr, c_pc};

  always_comb begin
    cur = '0;
    if (in_range) cur = mem[c_idx];
    merged = cur;
    for (int i = 0; i < 4; i++) begin
      if (c_we && c_be[i]) merged[8*i +: 8] = c_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ready   <= 1'b0;
      ack     <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
      cnt     <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      ack   <= 1'b0;
      rdata <= '0;
      err   <= 1'b0;
      unique case (state)
        IDLE: begin
          ready <= 1'b1;
          if (accept) begin
            we_q    <= we;
            be_q    <= be;
            addr_q  <= addr;
            wdata_q <= wdata;
            pc_q    <= pc;
            ready   <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= BUSY;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        BUSY: begin
          if (cnt == 4'd0) state <= RESP;
          else cnt <= cnt - 4'd1;
        end
        RESP: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      if (commit) begin
        ack   <= 1'b1;
        err   <= ~in_range;
        rdata <= in_range ? merged : '0;
        if (c_we && in_range) mem[c_idx] <= merged;
      end
    end
  end

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset && commit && c_we && in_range && c_be != 4'b0000)
      $display("%d@%h: *%h <= %h", $time, c_pc,
               {c_addr[31:2], 2'b00}, merged);
  end
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances.
module tb_dm_responder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        req2 = 0, we2 = 0;
  logic [3:0]  be2 = 0;
  logic [31:0] addr2 = 0, wdata2 = 0, pc2 = 0;
  logic        ready2, ack2, err2;
  logic [31:0] rdata2;

  logic        req0 = 0, we0 = 0;
  logic [3:0]  be0 = 0;
  logic [31:0] addr0 = 0, wdata0 = 0, pc0 = 0;
  logic        ready0, ack0, err0;
  logic [31:0] rdata0;

  dm_responder #(.DEPTH(3072), .ADDR_W(12), .WAIT_CYCLES(2)) u2 (
    .clk(clk), .reset(reset), .req(req2), .we(we2), .be(be2),
    .addr(addr2), .wdata(wdata2), .pc(pc2),
    .ready(ready2), .ack(ack2), .rdata(rdata2), .err(err2)
  );

  dm_responder #(.DEPTH(3072), .ADDR_W(12), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .be(be0),
    .addr(addr0), .wdata(wdata0), .pc(pc0),
    .ready(ready0), .ack(ack0), .rdata(rdata0), .err(err0)
  );

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One transaction on the WAIT_CYCLES=2 instance; called at a negedge
  task automatic txn2(input vec_t v, input string name);
    int k;
    int lat;
    k = 0;
    while (!ready2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_ready"}, 32'(ready2), 32'd1);
    req2 = 1; we2 = v.we; be2 = v.be;
    addr2 = v.addr; wdata2 = v.wdata; pc2 = v.pc;
    @(negedge clk);
    req2 = 0; we2 = 1; be2 = 4'hF;
    addr2 = 32'h0000_0080; wdata2 = 32'hBAD0_BAD0;
    lat = 1;
    while (!ack2 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_lat"}, 32'(lat), 32'd3);
    chk({name, "_rdata"}, rdata2, v.exp_rd);
    chk({name, "_err"}, 32'(err2), 32'(v.exp_err));
    @(negedge clk);
    chk({name, "_ackpulse"}, 32'(ack2), 32'd0);
  endtask

  vec_t tab[14];
  vec_t seq0[9];

  initial begin
    tab[0]  = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'h0, 32'h0000_0000, 1'b0};
    tab[1]  = '{1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, 32'h0, 32'h1122_3344, 1'b0};
    tab[2]  = '{1'b1, 4'h5, 32'h0000_0020, 32'hAABB_CCDD, 32'h0, 32'h11BB_33DD, 1'b0};
    tab[3]  = '{1'b0, 4'hF, 32'h0000_0022, 32'h0,         32'h0, 32'h11BB_33DD, 1'b0};
    tab[4]  = '{1'b1, 4'hF, 32'h0000_0000, 32'hCAFE_F00D, 32'h0, 32'hCAFE_F00D, 1'b0};
    tab[5]  = '{1'b1, 4'hF, 32'h0000_3000, 32'hFFFF_FFFF, 32'h0, 32'h0000_0000, 1'b1};
    tab[6]  = '{1'b0, 4'hF, 32'h0000_0000, 32'h0,         32'h0, 32'hCAFE_F00D, 1'b0};
    tab[7]  = '{1'b1, 4'h0, 32'h0000_0020, 32'h0,         32'h0, 32'h11BB_33DD, 1'b0};
    tab[8]  = '{1'b1, 4'h8, 32'h0000_0020, 32'h7700_0000, 32'h0, 32'h77BB_33DD, 1'b0};
    tab[9]  = '{1'b0, 4'hF, 32'h0000_2FFC, 32'h0,         32'h0, 32'h0000_0000, 1'b0};
    tab[10] = '{1'b1, 4'h3, 32'h0000_2FFC, 32'h5A5A_5A5A, 32'h0, 32'h0000_5A5A, 1'b0};
    tab[11] = '{1'b1, 4'hF, 32'h0000_0007, 32'h1234_5678, 32'h0000_3008, 32'h1234_5678, 1'b0};
    tab[12] = '{1'b0, 4'hF, 32'h0000_0004, 32'h0,         32'h0, 32'h1234_5678, 1'b0};
    tab[13] = '{1'b0, 4'hF, 32'h0000_0080, 32'h0,         32'h0, 32'h0000_0000, 1'b0};

    for (int k = 0; k < 4; k++)
      seq0[k] = '{1'b1, 4'hF, 32'(k * 4), 32'h0101_0101 * 32'(k + 1),
                  32'h0, 32'h0101_0101 * 32'(k + 1), 1'b0};
    for (int k = 0; k < 4; k++)
      seq0[4+k] = '{1'b0, 4'hF, 32'(k * 4), 32'h0,
                    32'h0, 32'h0101_0101 * 32'(k + 1), 1'b0};
    seq0[8] = '{1'b0, 4'hF, 32'h0000_0100, 32'h0, 32'h0, 32'h0, 1'b0};

    // Reset held for three cycles with a request pending
    req2 = 1; addr2 = 32'h10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_ready", 32'(ready2), 32'd0);
      chk("rst_ack", 32'(ack2), 32'd0);
    end
    chk("rst_rdata", rdata2, 32'd0);
    chk("rst_err", 32'(err2), 32'd0);
    req2 = 0;
    reset = 1;
    @(negedge clk);
    chk("ready_after_release", 32'(ready2), 32'd1);

    for (int i = 0; i < 14; i++) txn2(tab[i], $sformatf("vec%0d", i));

    // Reset during BUSY drops the write
    req2 = 1; we2 = 1; be2 = 4'hF;
    addr2 = 32'h40; wdata2 = 32'hDEAD_BEEF;
    @(negedge clk);
    req2 = 0;
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst_ready", 32'(ready2), 32'd0);
      chk("midrst_ack", 32'(ack2), 32'd0);
    end
    reset = 1;
    @(negedge clk);
    chk("midrst_ready_rel", 32'(ready2), 32'd1);
    txn2('{1'b0, 4'hF, 32'h40, 32'h0, 32'h0, 32'h0, 1'b0}, "midrst_rd40");
    txn2('{1'b0, 4'hF, 32'h20, 32'h0, 32'h0, 32'h0, 1'b0}, "midrst_rd20");

    // Zero-wait instance with req held high: ops on even phases, junk on odd
    begin
      int k;
      k = 0;
      while (!ready0 && k < 20) begin
        @(negedge clk);
        k++;
      end
    end
    req0 = 1;
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("b2b_ready%0d", i), 32'(ready0), 32'(i % 2 == 0));
      chk($sformatf("b2b_ack%0d", i), 32'(ack0), 32'(i % 2 == 1));
      if (i % 2 == 1)
        chk($sformatf("b2b_rdata%0d", i / 2), rdata0, seq0[i/2].exp_rd);
      if (i % 2 == 0) begin
        we0 = seq0[i/2].we; be0 = seq0[i/2].be;
        addr0 = seq0[i/2].addr; wdata0 = seq0[i/2].wdata;
      end else begin
        we0 = 1; be0 = 4'hF;
        addr0 = 32'h0000_0100; wdata0 = 32'hBAD0_BAD0;
      end
      @(negedge clk);
    end
    req0 = 0;
    chk("b2b_err", 32'(err0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Memory-side responder for the CPU data-memory port: the target end of the M-stage load/store interface.
- Accepts one request at a time over a req/ready handshake and holds the request for a fixed number of wait states.
- Commits writes with byte enables, then returns read data with a one-cycle ack.
- Replaces the zero-latency DM so the pipeline stall logic can be exercised against a multi-cycle memory.

Parameters:
- DEPTH, 3072: number of 32-bit words of storage (12 KiB).
- ADDR_W, 12: word-index width; must satisfy 2^ADDR_W >= DEPTH.
- WAIT_CYCLES, 2: number of BUSY cycles inserted between accept and response (0..15).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous active-low reset; 0 = reset asserted.
- req  input  1  request valid from the CPU M stage.
- we  input  1  1 = write, 0 = read; sampled with req.
- be  input  4  byte enables; be[i] selects byte lane i, bits [8i+7:8i].
- addr  input  32  byte address; addr[1:0] is ignored; word index is addr[ADDR_W+1:2].
- wdata  input  32  write data, lane-aligned.
- pc  input  32  PC of the requesting instruction; used only for tracing.
- ready  output  1  responder idle and able to accept a request.
- ack  output  1  one-cycle pulse: transaction complete.
- rdata  output  32  response data; valid only while ack = 1.
- err  output  1  out-of-range flag; valid only while ack = 1.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE; ready = 0, ack = 0, rdata = 0, err = 0.
  - All DEPTH words cleared to 0.
  - Any in-flight transaction is dropped; no write is committed.
- ready is registered.
  - It rises on the first clk edge after reset is released.
  - Thereafter ready = 1 exactly while state == IDLE.
- Accept: on a clk edge with req & ready, latch we, be, addr, wdata and pc into holding registers.
  - Input changes after the accept edge have no effect on the transaction.
  - req while ready = 0 is ignored; the requester must hold req until it sees ready.
- State machine:
  - IDLE -> BUSY on accept when WAIT_CYCLES > 0; a wait counter is loaded with WAIT_CYCLES-1.
  - IDLE -> RESP on accept when WAIT_CYCLES == 0.
  - BUSY: counter decrements every cycle; BUSY -> RESP on the edge where the counter is 0.
  - RESP -> IDLE unconditionally after one cycle.
- Latency: ack is high in the (WAIT_CYCLES+1)-th cycle after the accept edge.
  - Back-to-back throughput is one transaction per WAIT_CYCLES+2 cycles, because the IDLE cycle is mandatory.
- The transaction is committed on the edge that enters RESP.
  - Read: rdata = mem[idx].
  - Write: mem[idx] lane i is replaced by wdata lane i where be[i] = 1; other lanes keep their value.
  - Write: rdata = the merged word after the update.
  - be = 0000 on a write: no change to memory; rdata = the current word; err = 0.
- Out of range: latched word index >= DEPTH gives err = 1 and rdata = 0 during ack; no write occurs.
- ack, rdata and err are registered and driven only in RESP. In all other states ack = 0, err = 0 and rdata = 0.
- Simultaneous events:
  - A new req during RESP is not accepted; ready is still 0 in that cycle.
  - The new req is accepted on the next edge, from IDLE.
  - reset asserted in any state overrides everything, including a commit on the same edge.

Optional Feature:
- Macro: DM_TRACE_EN.
- Defined: on every committed write (in range, be != 0), emit $display("%d@%h: *%h <= %h", $time, pc_latched, {addr_latched[31:2],2'b00}, merged_word) on the commit edge.
  - No message is emitted for reads, for out-of-range accesses, or for be = 0000 writes.
- Undefined: no display statements are compiled in; all other behaviour is identical.

Test Plan:
- Reset and first accept, WAIT_CYCLES=2: hold reset=0 for 3 cycles, release it, then issue a read of addr 0x0000_0010.
  - ready=0 and ack=0 throughout reset; ready=1 one edge after release.
  - ack=1 exactly 3 cycles after accept with rdata=0x0000_0000.
- Byte-lane write: write 0x11223344 be=1111 to addr 0x20, then write 0xAABBCCDD be=0101 to addr 0x20.
  - Second ack: rdata=0x11BB33DD.
  - A following read of addr 0x22 (addr[1:0] ignored) returns 0x11BB33DD.
- Out of range, DEPTH=3072: write 0xFFFFFFFF to addr 0x0000_3000.
  - ack with err=1 and rdata=0.
  - A read of addr 0x0 still returns its previous value; with DM_TRACE_EN defined, no trace line is printed.
- Back-to-back with req held high for 4 reads and WAIT_CYCLES=0:
  - ack pulses every 2 cycles.
  - ready toggles 1,0,1,0; the inputs presented while ready=0 are never latched.
- Reset mid-operation: accept a write of 0xDEADBEEF to addr 0x40, then assert reset during BUSY.
  - ack never rises; ready=0 during reset.
  - After release, a read of addr 0x40 returns 0x00000000.
- Trace, DM_TRACE_EN defined, pc=0x00003008: write 0x12345678 to addr 0x7 with be=1111.
  - Exactly one line printed, containing "00003008: *00000004 <= 12345678".
